// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared types and defaults for the fetch/decode/sequence controller.
package fetch_decode_ctrl_pkg;

    localparam int unsigned PC_W_DEF    = 8;
    localparam int unsigned INSTR_W_DEF = 9;
    localparam int unsigned CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWriteback,
        StHalt
    } state_t;

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpAnd  = 3'b010,
        OpLdi  = 3'b011,
        OpLd   = 3'b100,
        OpSt   = 3'b101,
        OpBz   = 3'b110,
        OpHalt = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluSub   = 2'b01,
        AluAnd   = 2'b10,
        AluPassB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PcHold,
        PcInc,
        PcBranch,
        PcZero
    } pc_sel_t;

    // LD/ST use ADD so the ALU forms the memory address.
    function automatic alu_op_t alu_for_op(input opcode_t op);
        case (op)
            OpSub:   return AluSub;
            OpAnd:   return AluAnd;
            OpLdi:   return AluPassB;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/fetch_decode_ctrl_if.sv
// Controller-side bundle: ROM/flag inputs and reg_file/ALU control outputs.
interface fetch_decode_ctrl_if #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned CNT_W   = 16
);

    logic               i_start;
    logic [INSTR_W-1:0] i_instr;
    logic               i_zero;
    logic [PC_W-1:0]    o_pc;
    logic [2:0]         o_reg1;
    logic [2:0]         o_reg2;
    logic [2:0]         o_reg_dest;
    logic               o_reg_wr;
    logic               o_mem_wr;
    logic [1:0]         o_alu_op;
    logic               o_sel_imm;
    logic               o_sel_mem;
    logic               o_done;
    logic [CNT_W-1:0]   o_cycle_count;

    modport master (
        input  i_start, i_instr, i_zero,
        output o_pc, o_reg1, o_reg2, o_reg_dest, o_reg_wr, o_mem_wr,
        output o_alu_op, o_sel_imm, o_sel_mem, o_done, o_cycle_count
    );

    modport slave (
        output i_start, i_instr, i_zero,
        input  o_pc, o_reg1, o_reg2, o_reg_dest, o_reg_wr, o_mem_wr,
        input  o_alu_op, o_sel_imm, o_sel_mem, o_done, o_cycle_count
    );

endinterface

// File: rtl/fetch_decode_ctrl_pc_unit.sv
// Program counter: hold, +1, +sign-extended 6-bit offset, or load zero.
module fetch_decode_ctrl_pc_unit
    import fetch_decode_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  pc_sel_t         i_sel,
    input  logic [5:0]      i_off6,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_off_sext;

    assign w_off_sext = {{(PC_W-6){i_off6[5]}}, i_off6};

    // Additions are modulo 2^PC_W, so 255+1 and backward branches wrap naturally.
    always_comb begin
        w_pc_next = r_pc;
        case (i_sel)
            PcInc:    w_pc_next = r_pc + PC_W'(1);
            PcBranch: w_pc_next = r_pc + w_off_sext;
            PcZero:   w_pc_next = '0;
            default:  w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/sequence controller: FSM, IR, decode and cycle counter.
module fetch_decode_ctrl
    import fetch_decode_ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input logic                i_clk,
    input logic                i_rst,
    fetch_decode_ctrl_if.master bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic [INSTR_W-1:0] r_ir;
    logic [CNT_W-1:0]   r_cnt;

    opcode_t            w_op;
    pc_sel_t            w_pc_sel;
    logic               w_ir_load;
    logic               w_cnt_clr;
    logic               w_reg_wr;
    logic               w_mem_wr;
    alu_op_t            w_alu_op;
    logic               w_sel_imm;
    logic               w_sel_mem;
    logic [PC_W-1:0]    w_pc;

    assign w_op = opcode_t'(r_ir[8:6]);

    always_comb begin
        w_state_next = r_state;
        w_pc_sel     = PcHold;
        w_ir_load    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_reg_wr     = 1'b0;
        w_mem_wr     = 1'b0;
        w_alu_op     = AluAdd;
        w_sel_imm    = 1'b0;
        w_sel_mem    = 1'b0;
        case (r_state)
            StIdle, StHalt: begin
                if (bus.i_start) begin
                    w_state_next = StFetch;
                    w_pc_sel     = PcZero;
                    w_cnt_clr    = 1'b1;
                end
            end
            StFetch: begin
                w_ir_load    = 1'b1;
                w_state_next = StDecode;
            end
            StDecode: begin
                w_state_next = (w_op == OpHalt) ? StHalt : StExec;
            end
            StExec: begin
                w_alu_op  = alu_for_op(w_op);
                w_sel_imm = (w_op == OpLdi);
                w_sel_mem = (w_op == OpLd);
                case (w_op)
                    OpSt: begin
                        w_mem_wr     = 1'b1;
                        w_pc_sel     = PcInc;
                        w_state_next = StFetch;
                    end
                    OpBz: begin
                        w_pc_sel     = bus.i_zero ? PcBranch : PcInc;
                        w_state_next = StFetch;
                    end
                    default: w_state_next = StWriteback;
                endcase
            end
            StWriteback: begin
                w_alu_op     = alu_for_op(w_op);
                w_sel_imm    = (w_op == OpLdi);
                w_sel_mem    = (w_op == OpLd);
                w_reg_wr     = 1'b1;
                w_pc_sel     = PcInc;
                w_state_next = StFetch;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_ir_load) begin
                r_ir <= bus.i_instr;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_state != StIdle && r_state != StHalt && r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    fetch_decode_ctrl_pc_unit #(
        .PC_W (PC_W)
    ) u_pc_unit (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sel  (w_pc_sel),
        .i_off6 (r_ir[5:0]),
        .o_pc   (w_pc)
    );

    assign bus.o_pc          = w_pc;
    assign bus.o_reg1        = r_ir[5:3];
    assign bus.o_reg2        = r_ir[2:0];
    assign bus.o_reg_dest    = r_ir[5:3];
    assign bus.o_reg_wr      = w_reg_wr;
    assign bus.o_mem_wr      = w_mem_wr;
    assign bus.o_alu_op      = w_alu_op;
    assign bus.o_sel_imm     = w_sel_imm;
    assign bus.o_sel_mem     = w_sel_mem;
    assign bus.o_done        = (r_state == StHalt);
    assign bus.o_cycle_count = r_cnt;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: hand-computed vectors over two instances.
module tb_fetch_decode_ctrl;

    localparam logic [8:0] I_HALT = 9'b111_000_000;
    localparam logic [8:0] I_ADD0 = 9'b000_000_000;
    localparam logic [8:0] I_LDI5 = 9'b011_000_101;
    localparam logic [8:0] I_ST   = 9'b101_010_100;
    localparam logic [8:0] I_BZM1 = 9'b110_111111;
    localparam logic [8:0] I_BZP2 = 9'b110_000010;

    logic       clk;
    logic       rst;
    logic [8:0] rom   [256];
    logic [8:0] rom_s [256];
    int         n_checks;
    int         n_errors;

    fetch_decode_ctrl_if #(.PC_W(8), .INSTR_W(9), .CNT_W(16)) bus ();
    fetch_decode_ctrl_if #(.PC_W(8), .INSTR_W(9), .CNT_W(4))  bus_s ();

    fetch_decode_ctrl #(.PC_W(8), .INSTR_W(9), .CNT_W(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    fetch_decode_ctrl #(.PC_W(8), .INSTR_W(9), .CNT_W(4)) dut_sat (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_s)
    );

    assign bus.i_instr   = rom[bus.o_pc];
    assign bus_s.i_instr = rom_s[bus_s.o_pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rom_fill_halt();
        for (int i = 0; i < 256; i++) rom[i] = I_HALT;
    endtask

    // Leaves the DUT in FETCH at PC=0 (cycle 1 after START).
    task automatic do_start();
        bus.i_start = 1'b1;
        step(1);
        bus.i_start = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_zero    = 1'b0;
        bus_s.i_start = 1'b0;
        bus_s.i_zero  = 1'b0;
        rom_fill_halt();
        for (int i = 0; i < 256; i++) rom_s[i] = (i < 10) ? I_ADD0 : I_HALT;
        step(2);

        check("rst_pc", 32'(bus.o_pc), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_regwr", 32'(bus.o_reg_wr), 32'd0);
        check("rst_memwr", 32'(bus.o_mem_wr), 32'd0);
        check("rst_cnt", 32'(bus.o_cycle_count), 32'd0);
        check("rst_reg1", 32'(bus.o_reg1), 32'd0);
        check("rst_alu", 32'(bus.o_alu_op), 32'd0);
        rst = 1'b0;
        step(2);
        check("idle_pc", 32'(bus.o_pc), 32'd0);

        // LDI then HALT
        rom[0] = I_LDI5;
        rom[1] = I_HALT;
        do_start();
        step(2);
        check("ldi_exec_regwr", 32'(bus.o_reg_wr), 32'd0);
        step(1);
        check("ldi_wb_regwr", 32'(bus.o_reg_wr), 32'd1);
        check("ldi_wb_dest", 32'(bus.o_reg_dest), 32'd0);
        check("ldi_wb_selimm", 32'(bus.o_sel_imm), 32'd1);
        check("ldi_wb_alu", 32'(bus.o_alu_op), 32'd3);
        check("ldi_wb_memwr", 32'(bus.o_mem_wr), 32'd0);
        step(2);
        check("ldi_predone", 32'(bus.o_done), 32'd0);
        step(1);
        check("ldi_done", 32'(bus.o_done), 32'd1);
        check("ldi_cnt", 32'(bus.o_cycle_count), 32'd6);
        check("ldi_halt_pc", 32'(bus.o_pc), 32'd1);
        step(3);
        check("halt_frozen_pc", 32'(bus.o_pc), 32'd1);
        check("halt_frozen_cnt", 32'(bus.o_cycle_count), 32'd6);

        // ST, restarted from HALT
        rom[0] = I_ST;
        do_start();
        check("restart_pc", 32'(bus.o_pc), 32'd0);
        check("restart_cnt", 32'(bus.o_cycle_count), 32'd0);
        check("restart_done", 32'(bus.o_done), 32'd0);
        step(1);
        check("st_reg1", 32'(bus.o_reg1), 32'd2);
        check("st_reg2", 32'(bus.o_reg2), 32'd4);
        check("st_dec_memwr", 32'(bus.o_mem_wr), 32'd0);
        step(1);
        check("st_exec_memwr", 32'(bus.o_mem_wr), 32'd1);
        check("st_exec_regwr", 32'(bus.o_reg_wr), 32'd0);
        check("st_exec_alu", 32'(bus.o_alu_op), 32'd0);
        step(1);
        check("st_next_memwr", 32'(bus.o_mem_wr), 32'd0);
        check("st_next_regwr", 32'(bus.o_reg_wr), 32'd0);
        check("st_next_pc", 32'(bus.o_pc), 32'd1);
        step(2);
        check("st_done", 32'(bus.o_done), 32'd1);

        // Reset in the middle of ST's EXEC
        do_start();
        step(2);
        check("st2_exec_memwr", 32'(bus.o_mem_wr), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_memwr", 32'(bus.o_mem_wr), 32'd0);
        check("midrst_pc", 32'(bus.o_pc), 32'd0);
        check("midrst_done", 32'(bus.o_done), 32'd0);
        check("midrst_cnt", 32'(bus.o_cycle_count), 32'd0);
        step(1);
        rst = 1'b0;
        step(3);
        check("postrst_idle_cnt", 32'(bus.o_cycle_count), 32'd0);
        check("postrst_idle_pc", 32'(bus.o_pc), 32'd0);

        // START during DECODE is ignored
        rom[0] = I_LDI5;
        do_start();
        step(1);
        bus.i_start = 1'b1;
        step(1);
        bus.i_start = 1'b0;
        check("ign_start_pc", 32'(bus.o_pc), 32'd0);
        check("ign_start_cnt", 32'(bus.o_cycle_count), 32'd2);
        check("ign_start_selimm", 32'(bus.o_sel_imm), 32'd1);
        step(1);
        check("ign_start_regwr", 32'(bus.o_reg_wr), 32'd1);
        step(1);
        check("ign_start_pc1", 32'(bus.o_pc), 32'd1);
        step(2);
        check("ign_start_done", 32'(bus.o_done), 32'd1);

        // BZ -1 at PC=3, taken and not taken
        rom_fill_halt();
        rom[0] = I_ADD0;
        rom[1] = I_ADD0;
        rom[2] = I_ADD0;
        rom[3] = I_BZM1;
        bus.i_zero = 1'b1;
        do_start();
        step(12);
        check("bz_at3_pc", 32'(bus.o_pc), 32'd3);
        step(3);
        check("bz_taken_pc", 32'(bus.o_pc), 32'd2);
        bus.i_zero = 1'b0;
        step(4);
        check("bz_back3_pc", 32'(bus.o_pc), 32'd3);
        step(3);
        check("bz_nottaken_pc", 32'(bus.o_pc), 32'd4);
        step(2);
        check("bz_done", 32'(bus.o_done), 32'd1);

        // PC wrap at 255 via ADD and via taken BZ +2
        rom_fill_halt();
        rom[0]   = I_BZM1;
        rom[255] = I_ADD0;
        bus.i_zero = 1'b1;
        do_start();
        check("wrap_start_pc", 32'(bus.o_pc), 32'd0);
        step(3);
        check("wrap_back_pc", 32'(bus.o_pc), 32'd255);
        step(4);
        check("wrap_add_pc", 32'(bus.o_pc), 32'd0);
        rom[255] = I_BZP2;
        step(3);
        check("wrap_back2_pc", 32'(bus.o_pc), 32'd255);
        step(3);
        check("wrap_bz_pc", 32'(bus.o_pc), 32'd1);
        step(2);
        check("wrap_done", 32'(bus.o_done), 32'd1);

        // Saturation on the 4-bit counter instance
        bus_s.i_start = 1'b1;
        step(1);
        bus_s.i_start = 1'b0;
        step(9);
        check("sat_mid_cnt", 32'(bus_s.o_cycle_count), 32'd9);
        step(40);
        check("sat_done", 32'(bus_s.o_done), 32'd1);
        check("sat_cnt", 32'(bus_s.o_cycle_count), 32'd15);
        check("sat_pc", 32'(bus_s.o_pc), 32'd10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
